hs32_bram_arb: RTL

- Two-port round-robin arbiter that shares the single hs32_bram_ctl instance between two requesters.
  - Port 0: the HS32 CPU memory bus.
  - Port 1: the management/Wishbone bridge.
- Sequences each access through IDLE/ISSUE/WAIT/DONE, registering the winning request onto the controller strobe interface and returning a registered ack plus read data to the winner.
- A watchdog bounds each access so a missing controller ack cannot hang either requester.

---
 rtl/hs32_bram_arb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/hs32_bram_arb.sv
// Two-port round-robin arbiter in front of the single hs32_bram_ctl.
// Port 0 is the CPU memory bus, port 1 the management/Wishbone bridge.
// Each access walks IDLE -> ISSUE -> WAIT -> DONE. A watchdog in WAIT
// forces an error completion so a silent controller cannot hang a requester.
module hs32_bram_arb #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [31:0]   i_dwrite0,
  input  logic [31:0]   i_dwrite1,
  input  logic          i_rw0,
  input  logic          i_rw1,
  input  logic          i_stb0,
  input  logic          i_stb1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic          o_err0,
  output logic          o_err1,
  output logic [31:0]   o_dread0,
  output logic [31:0]   o_dread1,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_dwrite,
  output logic          o_rw,
  output logic          o_stb,
  input  logic          i_ack,
  input  logic [31:0]   i_dread
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic       grant, last_grant;
  logic [7:0] watchdog;

  logic req_any, pick, wd_expire;
  logic do_grant, do_cap, do_to, do_fin;

  // On a tie the port that did not win last time goes next; a lone
  // requester always wins.
  assign req_any   = i_stb0 | i_stb1;
  assign pick      = (i_stb0 & i_stb1) ? ~last_grant : i_stb1;
  assign wd_expire = (watchdog == WD_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  // Next-state logic; an ack during ISSUE short-circuits straight to DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_any) state_nx = ISSUE;
      ISSUE:   state_nx = i_ack ? DONE : WAIT;
      WAIT:    if (i_ack || wd_expire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output/control decode; a real ack beats a simultaneous watchdog expiry
  always_comb begin
    do_grant = 1'b0;
    do_cap   = 1'b0;
    do_to    = 1'b0;
    case (state)
      IDLE:    do_grant = req_any;
      ISSUE:   do_cap   = i_ack;
      WAIT: begin
        do_cap = i_ack;
        do_to  = ~i_ack & wd_expire;
      end
      default: ;
    endcase
    do_fin = do_cap | do_to;
  end

  // Request latch toward the controller, grant bookkeeping and watchdog
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stb      <= 1'b0;
      o_addr     <= '0;
      o_dwrite   <= '0;
      o_rw       <= 1'b0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      watchdog   <= '0;
    end else begin
      o_stb <= do_grant;
      if (do_grant) begin
        o_addr     <= pick ? i_addr1   : i_addr0;
        o_dwrite   <= pick ? i_dwrite1 : i_dwrite0;
        o_rw       <= pick ? i_rw1     : i_rw0;
        grant      <= pick;
        last_grant <= pick;
      end
      if (state == ISSUE)     watchdog <= '0;
      else if (state == WAIT) watchdog <= watchdog + 8'd1;
    end
  end

  // Completion pulses and read data, steered to the granted port only
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ack0   <= 1'b0;
      o_ack1   <= 1'b0;
      o_err0   <= 1'b0;
      o_err1   <= 1'b0;
      o_dread0 <= '0;
      o_dread1 <= '0;
    end else begin
      o_ack0 <= do_fin & ~grant;
      o_ack1 <= do_fin &  grant;
      o_err0 <= do_to  & ~grant;
      o_err1 <= do_to  &  grant;
      if (do_fin && !grant) o_dread0 <= do_cap ? i_dread : 32'h0;
      if (do_fin &&  grant) o_dread1 <= do_cap ? i_dread : 32'h0;
    end
  end

endmodule
